// File: rtl/axi_lite_write_slave_if.sv
// AXI4-Lite write channels (AW, W, B) bundled for the write-slave controller.
// Master drives valids/payloads and BREADY; slave drives readies and the response.
interface axi_lite_write_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      AWVALID;
    logic                      AWREADY;
    logic [ADDR_WIDTH-1:0]     AWADDR;
    logic [2:0]                AWPROT;
    logic                      WVALID;
    logic                      WREADY;
    logic [DATA_WIDTH-1:0]     WDATA;
    logic [DATA_WIDTH/8-1:0]   WSTRB;
    logic                      BVALID;
    logic                      BREADY;
    logic [1:0]                BRESP;

    modport master (
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
        input  AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
        output AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite write slave: one-entry AW/W holding, single-cycle reg write strobe, B response.
// Latency: pair complete at edge N -> reg_wr_en in cycle N+1 -> BVALID from cycle N+2.
// Backpressure: readies are registered and drop while a beat is held or a write is in flight; PROT_CHECK_EN rejects unprivileged writes.
module axi_lite_write_slave #(
    parameter int  ADDR_WIDTH = 32,
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_REGS   = 16,
    localparam int STRB_W     = DATA_WIDTH / 8,
    localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    axi_lite_write_slave_if.slave  s_axi,
    output logic                   reg_wr_en,
    output logic [IDX_W-1:0]       reg_wr_idx,
    output logic [DATA_WIDTH-1:0]  reg_wr_data,
    output logic [STRB_W-1:0]      reg_wr_strb
);
    localparam int         SHIFT  = $clog2(STRB_W);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   aw_held_q, w_held_q;
    logic                   awready_q, wready_q;
    logic                   bvalid_q;
    logic [1:0]             bresp_q;
    logic [ADDR_WIDTH-1:0]  awaddr_q;
    logic [2:0]             awprot_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [STRB_W-1:0]      wstrb_q;
    logic                   reg_wr_en_q;
    logic [IDX_W-1:0]       reg_wr_idx_q;

    logic                   aw_fire, w_fire;
    logic                   aw_held_d, w_held_d;
    logic [ADDR_WIDTH-1:0]  awaddr_d;
    logic [2:0]             awprot_d;
    logic [ADDR_WIDTH-1:0]  idx_full;
    logic                   in_range, prot_ok, accept;
    logic                   unused_prot;

    // Decode looks through a beat captured on this very edge, so the pair completes without a bubble.
    always_comb begin
        aw_fire   = s_axi.AWVALID && awready_q;
        w_fire    = s_axi.WVALID && wready_q;
        aw_held_d = aw_held_q || aw_fire;
        w_held_d  = w_held_q || w_fire;
        awaddr_d  = aw_fire ? s_axi.AWADDR : awaddr_q;
        awprot_d  = aw_fire ? s_axi.AWPROT : awprot_q;
        idx_full  = awaddr_d >> SHIFT;
        in_range  = idx_full < ADDR_WIDTH'(NUM_REGS);
        accept    = in_range && prot_ok;
    end

`ifdef PROT_CHECK_EN
    assign prot_ok = awprot_d[0];
`else
    assign prot_ok = 1'b1;
`endif
    assign unused_prot = ^{awprot_d, awprot_q};

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= IDLE;
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= OKAY;
            awaddr_q     <= '0;
            awprot_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            reg_wr_en_q  <= 1'b0;
            reg_wr_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aw_fire) begin
                        awaddr_q <= s_axi.AWADDR;
                        awprot_q <= s_axi.AWPROT;
                    end
                    if (w_fire) begin
                        wdata_q <= s_axi.WDATA;
                        wstrb_q <= s_axi.WSTRB;
                    end
                    aw_held_q <= aw_held_d;
                    w_held_q  <= w_held_d;
                    if (aw_held_d && w_held_d) begin
                        state_q      <= WRITE;
                        reg_wr_en_q  <= accept;
                        reg_wr_idx_q <= idx_full[IDX_W-1:0];
                        bresp_q      <= accept ? OKAY : SLVERR;
                        awready_q    <= 1'b0;
                        wready_q     <= 1'b0;
                    end else begin
                        awready_q <= !aw_held_d;
                        wready_q  <= !w_held_d;
                    end
                end
                WRITE: begin
                    state_q     <= RESP;
                    reg_wr_en_q <= 1'b0;
                    bvalid_q    <= 1'b1;
                    aw_held_q   <= 1'b0;
                    w_held_q    <= 1'b0;
                end
                RESP: begin
                    if (bvalid_q && s_axi.BREADY) begin
                        state_q   <= IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = wready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign reg_wr_en     = reg_wr_en_q;
    assign reg_wr_idx    = reg_wr_idx_q;
    assign reg_wr_data   = wdata_q;
    assign reg_wr_strb   = wstrb_q;
endmodule
